// File: rtl/ram_bus_pkg.sv
// rtl/ram_bus_pkg.sv - shared FSM state type, width defaults and read/write codes for ram_bus_master
package ram_bus_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_ACK,
    RD_ISSUE,
    RD_CAP
  } state_t;

endpackage

// File: rtl/ram_bus_if.sv
// rtl/ram_bus_if.sv - request/response and RAM control bundle; req_len exists only with RAM_BURST_EN
interface ram_bus_if
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef RAM_BURST_EN
  logic [1:0]        req_len;
`endif
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;

  modport master (
`ifdef RAM_BURST_EN
    input  req_len,
`endif
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, mem_addr, mem_rw
  );

  modport slave (
`ifdef RAM_BURST_EN
    output req_len,
`endif
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, mem_addr, mem_rw
  );

endinterface

// File: rtl/ram_burst_ctr.sv
// rtl/ram_burst_ctr.sv - burst beat counter and wrapping word address, used only with RAM_BURST_EN
module ram_burst_ctr #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [1:0]        load_cnt,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [1:0] cnt;

  // Address wraps naturally at 2^ADDR_W; the count never steps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      cnt  <= 2'd0;
    end else if (load) begin
      addr <= load_addr;
      cnt  <= load_cnt;
    end else if (step && (cnt != 2'd0)) begin
      addr <= addr + ADDR_W'(1);
      cnt  <= cnt - 2'd1;
    end
  end

  assign last = (cnt == 2'd0);

endmodule

// File: rtl/ram_bus_master.sv
// rtl/ram_bus_master.sv - request/response master for a shared-data-bus RAM; RAM_BURST_EN adds multi-beat reads
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_bus_if.master        bus,
  inout  wire [DATA_W-1:0] mem_data
);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              beat_last;
  logic              drive_en;
  logic              mem_rw_c;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    drive_en   = 1'b0;
    mem_rw_c   = RW_READ;
    case (state)
      IDLE:     if (accept) next_state = (bus.req_rw == RW_READ) ? RD_ISSUE : WR;
      WR: begin
        next_state = WR_ACK;
        drive_en   = 1'b1;
        mem_rw_c   = RW_WRITE;
      end
      WR_ACK:   next_state = IDLE;
      RD_ISSUE: next_state = RD_CAP;
      RD_CAP:   next_state = beat_last ? IDLE : RD_ISSUE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wdata_q <= '0;
    else if (accept) wdata_q <= bus.req_wdata;
  end

`ifdef RAM_BURST_EN
  logic step;
  assign step = (state == RD_CAP) && !beat_last;

  ram_burst_ctr #(
    .ADDR_W(ADDR_W)
  ) u_burst_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_addr(bus.req_addr),
    .load_cnt ((bus.req_rw == RW_READ) ? bus.req_len : 2'd0),
    .step     (step),
    .addr     (addr_q),
    .last     (beat_last)
  );
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      addr_q <= '0;
    else if (accept) addr_q <= bus.req_addr;
  end

  assign beat_last = 1'b1;
`endif

  // Responses are registered: a write ack shows during WR_ACK, read data the cycle after RD_CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.req_ready <= (next_state == IDLE);
      bus.rsp_valid <= (state == WR) || (state == RD_CAP);
      bus.rsp_last  <= (state == WR) || ((state == RD_CAP) && beat_last);
      bus.rsp_rdata <= (state == RD_CAP) ? mem_data : '0;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_rw   = mem_rw_c;
  assign mem_data     = drive_en ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_bus_master.sv
// tb/tb_ram_bus_master.sv - self-checking bench for ram_bus_master; burst steps compile in with RAM_BURST_EN
module tb_ram_bus_master;
  import ram_bus_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  wire [DW-1:0] mem_data;

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mem_data(mem_data)
  );

  logic [1:0] req_len_tb;
`ifdef RAM_BURST_EN
  assign bus.req_len = req_len_tb;
`endif

  // RAM model: output enable follows mem_rw, write on the edge ending a mem_rw=0 cycle.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit ram_ready = 1'b0;
  assign mem_data = (bus.mem_rw == 1'b1) ? ram[bus.mem_addr] : 'z;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
      ram_ready <= 1'b1;
    end else if (bus.mem_rw == 1'b0) begin
      ram[bus.mem_addr] <= mem_data;
    end
  end

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int total = 0, passed = 0, fails = 0;
  int cyc = 0, n_acc = 0, wr_cycles = 0;
  logic [DW-1:0] cur_wdata = '0;
  logic [AW-1:0] cur_waddr = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && bus.req_valid && bus.req_ready) n_acc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus ownership: RAM's word whenever mem_rw=1, the in-flight write otherwise.
  always @(negedge clk) begin
    if (ram_ready) begin
      if (bus.mem_rw == 1'b0) begin
        wr_cycles++;
        chk("bus_write_owner", {bus.mem_addr, mem_data}, {cur_waddr, cur_wdata});
      end else begin
        chk("bus_read_owner", {16'h0, mem_data}, {16'h0, ram[bus.mem_addr]});
      end
    end
  end

  function automatic int exp_beats(input logic rw, input logic [1:0] len);
    exp_beats = 1;
`ifdef RAM_BURST_EN
    if (rw == RW_READ) exp_beats = int'(len) + 1;
`endif
  endfunction

  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input bit hold, output int acc);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      if (bus.req_ready === 1'b1) begin
        acc = cyc + 1;
        if (rw == RW_WRITE) begin
          cur_wdata = wd;
          cur_waddr = addr;
        end
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold || acc < 0) begin
      bus.req_valid = 1'b0;
      bus.req_rw    = 1'($urandom);
      bus.req_addr  = AW'($urandom);
      bus.req_wdata = DW'($urandom);
      req_len_tb    = 2'($urandom);
    end
  endtask

  int            got_n;
  logic [DW-1:0] got_data [0:7];
  logic          got_last [0:7];
  int            got_ofs  [0:7];
  logic [AW-1:0] addr_trace [0:39];

  task automatic collect(input int acc, input int window);
    got_n = 0;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      addr_trace[i] = bus.mem_addr;
      if (bus.rsp_valid === 1'b1 && got_n < 8) begin
        got_data[got_n] = bus.rsp_rdata;
        got_last[got_n] = bus.rsp_last;
        got_ofs[got_n]  = cyc - acc;
        got_n++;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [1:0] len, output int acc);
    int nb;
    logic [AW-1:0] a;
    nb = exp_beats(rw, len);
    req_len_tb = len;
    send(rw, addr, wd, 1'b0, acc);
    if (acc < 0) return;
    collect(acc, 2 * nb + 2);
    chk({tag, "_beats"}, got_n, nb);
    for (int k = 0; k < nb && k < got_n; k++) begin
      a = addr + AW'(k);
      chk({tag, "_data"}, got_data[k], (rw == RW_READ) ? ref_mem[a] : 16'h0);
      chk({tag, "_last"}, got_last[k], (k == nb - 1) ? 1 : 0);
      chk({tag, "_latency"}, got_ofs[k], (rw == RW_READ) ? 2 + 2 * k : 1);
    end
    if (rw == RW_WRITE) ref_mem[addr] = wd;
  endtask

  initial begin
    int acc, rel, w0, n0;
    logic [AW-1:0] bank_addr [0:5];
    logic [DW-1:0] bank_data [0:5];
    logic [AW-1:0] ra;
    logic rrw;

    bus.req_valid = 1'b0;
    bus.req_rw    = RW_READ;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    req_len_tb    = 2'd0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_last", bus.rsp_last, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_rw", bus.mem_rw, 1);
    chk("rst_mem_data", mem_data, 0);

    rel = cyc;
    rst_n = 1'b1;
    run_op("first_rd", RW_READ, 12'h000, 16'h0, 2'd0, acc);
    chk("first_accept_edge", acc, rel + 1);

    w0 = wr_cycles;
    run_op("wr3ff", RW_WRITE, 12'h3FF, 16'hA5C3, 2'd3, acc);
    chk("wr3ff_strobe_cycles", wr_cycles - w0, 1);
    run_op("rd3ff", RW_READ, 12'h3FF, 16'h0, 2'd0, acc);
    chk("rd3ff_word", got_data[0], 16'hA5C3);

    bank_addr = '{12'h000, 12'h3FF, 12'h400, 12'h7FF, 12'hC00, 12'hFFF};
    bank_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    for (int j = 0; j < 6; j++) run_op("bank_wr", RW_WRITE, bank_addr[j], bank_data[j], 2'd0, acc);
    for (int j = 0; j < 6; j++) begin
      run_op("bank_rd", RW_READ, bank_addr[j], 16'h0, 2'd0, acc);
      chk("bank_word", got_data[0], bank_data[j]);
    end

`ifdef RAM_BURST_EN
    run_op("pre_ffe", RW_WRITE, 12'hFFE, 16'h0001, 2'd0, acc);
    run_op("pre_fff", RW_WRITE, 12'hFFF, 16'h0002, 2'd0, acc);
    run_op("pre_000", RW_WRITE, 12'h000, 16'h0003, 2'd0, acc);
    run_op("pre_001", RW_WRITE, 12'h001, 16'h0004, 2'd0, acc);
    run_op("burst", RW_READ, 12'hFFE, 16'h0, 2'd3, acc);
    for (int k = 0; k < 4; k++) begin
      chk("burst_word", got_data[k], k + 1);
      chk("burst_mem_addr", addr_trace[1 + 2 * k], 32'(AW'(12'hFFE + k)));
    end
    chk("burst_last_pattern", {got_last[3], got_last[2], got_last[1], got_last[0]}, 4'b1000);
`endif

    req_len_tb = 2'd0;
    n0 = n_acc;
    send(RW_READ, 12'h7FF, 16'h0, 1'b1, acc);
    bus.req_addr = 12'hC00;
    chk("held_ready_issue", bus.req_ready, 0);
    @(negedge clk);
    chk("held_ready_cap", bus.req_ready, 0);
    @(negedge clk);
    chk("held_ready_idle", bus.req_ready, 1);
    chk("held_rsp1_valid", bus.rsp_valid, 1);
    chk("held_rsp1_data", bus.rsp_rdata, ref_mem[12'h7FF]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    collect(acc + 3, 5);
    chk("held_rsp2_count", got_n, 1);
    chk("held_rsp2_data", got_data[0], ref_mem[12'hC00]);
    chk("held_rsp2_latency", got_ofs[0], 2);
    chk("held_accept_count", n_acc - n0, 2);

    send(RW_WRITE, 12'h123, 16'hA5A5, 1'b0, acc);
    chk("mwr_in_write", bus.mem_rw, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mwr_mem_rw", bus.mem_rw, 1);
    chk("mwr_rsp_valid", bus.rsp_valid, 0);
    chk("mwr_bus_released", mem_data, ref_mem[12'h000]);
    chk("mwr_req_ready", bus.req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    collect(cyc, 4);
    chk("mwr_no_ack", got_n, 0);
    run_op("mwr_readback", RW_READ, 12'h123, 16'h0, 2'd0, acc);

    for (int n = 0; n < 40; n++) begin
      rrw = 1'($urandom);
      ra  = {2'($urandom), 6'($urandom_range(0, 1) ? 6'h3F : 6'h00), 4'($urandom)};
      run_op("rnd", rrw, ra, DW'($urandom), 2'($urandom), acc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
